// File: rtl/uart_byte_feeder.sv
// 8N1 UART receiver feeding a small byte FIFO, presented to the hashing core
// through a registered valid/ready handshake.
module uart_byte_feeder #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 16,
   parameter int ADDR_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   output logic              frame_err_o
);

   // state   | meaning
   // S_IDLE  | line idle, waiting for a falling edge
   // S_START | waiting half a bit to confirm the start bit
   // S_DATA  | sampling 8 data bits, LSB first, one per bit period
   // S_STOP  | sampling the stop bit, then push or flag a frame error
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

   localparam int                 BAUD_W   = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0]  BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0]  HALF_END = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W:0]    DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);

   logic              sync_a, rx_s;
   rx_state_t         state, state_next;
   logic [BAUD_W-1:0] baud, baud_next;
   logic [2:0]        bit_idx, bit_idx_next;
   logic [7:0]        shift, shift_next;
   logic              push, frame_err_next;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] rd_ptr, wr_ptr;
   logic [ADDR_W:0]   count, count_next;
   logic              full, pop, wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_a <= uart_rx_i;
         rx_s   <= sync_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         baud        <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= state_next;
         baud        <= baud_next;
         bit_idx     <= bit_idx_next;
         shift       <= shift_next;
         frame_err_o <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state;
      baud_next      = baud;
      bit_idx_next   = bit_idx;
      shift_next     = shift;
      push           = 1'b0;
      frame_err_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               baud_next  = '0;
               state_next = S_START;
            end
         end
         S_START: begin
            if (baud == HALF_END) begin
               baud_next = '0;
               if (rx_s) begin
                  state_next = S_IDLE;
               end else begin
                  bit_idx_next = '0;
                  state_next   = S_DATA;
               end
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         S_DATA: begin
            if (baud == BIT_END) begin
               baud_next           = '0;
               shift_next[bit_idx] = rx_s;
               if (bit_idx == 3'd7) begin
                  state_next = S_STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         S_STOP: begin
            if (baud == BIT_END) begin
               baud_next  = '0;
               state_next = S_IDLE;
               if (rx_s) begin
                  push = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
               end
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign full  = (count == DEPTH);
   assign pop   = valid_o & ready_i;
   assign wr_en = push & (~full | pop);

   always_comb begin
      count_next = count;
      case ({wr_en, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shift;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count   <= count_next;
         valid_o <= (count_next != '0);
         if (push && full && !pop) begin
            overflow_o <= 1'b1;
         end
      end
   end

   assign level_o = count;
   assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_byte_feeder.sv
// Directed bench for uart_byte_feeder: table of single frames plus hand-written
// glitch, overflow, full push/pop and mid-frame reset sequences.
module tb_uart_byte_feeder;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic [4:0] level;
   logic       overflow;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] got[$];
   int         fe_cnt = 0;

   uart_byte_feeder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx_i   (rx),
      .data_o      (data),
      .valid_o     (valid),
      .ready_i     (ready),
      .level_o     (level),
      .overflow_o  (overflow),
      .frame_err_o (frame_err)
   );

   always #5 clk = ~clk;

   // Transfer and frame-error monitor, sampled just after the falling edge.
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (valid && ready) got.push_back(data);
         if (frame_err) fe_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      int         exp_n;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base;
      int fe_base;

      vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      vecs[1] = '{8'h55, 1'b0, 0, 8'h00, 1};
      vecs[2] = '{8'h01, 1'b1, 1, 8'h01, 0};
      vecs[3] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
      vecs[4] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[6] = '{8'h81, 1'b1, 1, 8'h81, 0};

      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_data", 32'(data), 32'h00);
      check("reset_level", 32'(level), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Start-bit glitch shorter than half a bit must not start a frame.
      ready   = 1'b1;
      base    = got.size();
      fe_base = fe_cnt;
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      check("glitch_valid", 32'(valid), 32'd0);
      check("glitch_level", 32'(level), 32'd0);
      check("glitch_transfers", 32'(got.size() - base), 32'd0);
      check("glitch_frame_err", 32'(fe_cnt - fe_base), 32'd0);
      send_frame(8'h3C, 1'b1);
      check("after_glitch_n", 32'(got.size() - base), 32'd1);
      check("after_glitch_data", 32'(got.size() > base ? got[base] : 8'h00), 32'h3C);

      for (int v = 0; v < 7; v++) begin
         base    = got.size();
         fe_base = fe_cnt;
         send_frame(vecs[v].data, vecs[v].stop_ok);
         check("vec_transfers", 32'(got.size() - base), 32'(vecs[v].exp_n));
         check("vec_data", 32'(got.size() > base ? got[base] : 8'h00), 32'(vecs[v].exp_data));
         check("vec_frame_err", 32'(fe_cnt - fe_base), 32'(vecs[v].exp_fe));
         check("vec_level", 32'(level), 32'd0);
         check("vec_valid", 32'(valid), 32'd0);
         check("vec_overflow", 32'(overflow), 32'd0);
      end

      // Backpressure: fill, overflow on the 17th byte, then drain in order.
      ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send_frame(8'(i), 1'b1);
         check("fill_level", 32'(level), 32'(i + 1));
      end
      check("fill_no_overflow", 32'(overflow), 32'd0);
      send_frame(8'h10, 1'b1);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_level", 32'(level), 32'd16);
      check("ovf_head", 32'(data), 32'h00);
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", 32'(valid), 32'd1);
         check("drain_data", 32'(data), 32'(i));
         @(negedge clk);
      end
      check("drain_empty_valid", 32'(valid), 32'd0);
      check("drain_empty_level", 32'(level), 32'd0);
      check("drain_overflow_sticky", 32'(overflow), 32'd1);

      // Full FIFO with a pop on the same edge as the push.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_clears_overflow", 32'(overflow), 32'd0);
      ready = 1'b0;
      for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
      check("full_level", 32'(level), 32'd16);
      base = got.size();
      fork
         send_frame(8'h40, 1'b1);
         begin
            repeat (78) @(posedge clk);
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
         end
      join
      check("pushpop_level", 32'(level), 32'd16);
      check("pushpop_overflow", 32'(overflow), 32'd0);
      check("pushpop_n", 32'(got.size() - base), 32'd1);
      check("pushpop_popped", 32'(got.size() > base ? got[base] : 8'h00), 32'h20);
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("pushpop_drain_valid", 32'(valid), 32'd1);
         check("pushpop_drain_data", 32'(data), (i < 15) ? 32'(8'h21 + i) : 32'h40);
         @(negedge clk);
      end
      check("pushpop_drain_level", 32'(level), 32'd0);

      // Reset in the middle of a frame with bytes queued.
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      check("queued_level", 32'(level), 32'd3);
      fe_base = fe_cnt;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (30) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_valid", 32'(valid), 32'd0);
            check("midrst_level", 32'(level), 32'd0);
            check("midrst_data", 32'(data), 32'h00);
         end
      join
      check("midrst_no_push_level", 32'(level), 32'd0);
      check("midrst_no_push_valid", 32'(valid), 32'd0);
      check("midrst_frame_err", 32'(fe_cnt - fe_base), 32'd0);
      ready = 1'b1;
      base  = got.size();
      send_frame(8'h81, 1'b1);
      check("post_rst_n", 32'(got.size() - base), 32'd1);
      check("post_rst_data", 32'(got.size() > base ? got[base] : 8'h00), 32'h81);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
